// File: rtl/pix_reduce_pipe_if.sv
// Pixel stream handshake bundle for pix_reduce_pipe.
// master drives input beats and output backpressure; slave is the block.
interface pix_reduce_pipe_if #(
    parameter int NPIX = 2,
    parameter int CW   = 6
);
    localparam int PW = NPIX * 3 * CW;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pix;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;

    modport master (
        output in_valid,
        output in_pix,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_pix
    );

    modport slave (
        input  in_valid,
        input  in_pix,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_pix
    );
endinterface

// File: rtl/pix_reduce_pipe.sv
// Two-stage colour depth reducer: S1 rounds/saturates each channel,
// S2 applies the optional G/B swap and drives the registered output.
module pix_reduce_pipe #(
    parameter int NPIX = 2,
    parameter int CW   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    pix_reduce_pipe_if.slave      bus,
    input  logic [2:0]            switch_vals,
    input  logic [1:0]            switch_sels,
    input  logic                  change,
    input  logic                  swap_gb,
    output logic [15:0]           beat_cnt
);
    localparam int PXW = 3 * CW;
    localparam int PW  = NPIX * PXW;
    localparam int KW  = 4;
    localparam logic [CW:0]   ONE   = {{CW{1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_MAX = KW'(CW);

    logic          r_chg_q;
    logic [KW-1:0] r_kr;
    logic [KW-1:0] r_kg;
    logic [KW-1:0] r_kb;
    logic          r_v1;
    logic          r_v2;
    logic [PW-1:0] r_d1;
    logic [PW-1:0] r_d2;
    logic [15:0]   r_cnt;

    logic          w_chg_rise;
    logic [KW-1:0] w_kset;
    logic          w_s2_free;
    logic          w_s1_free;
    logic [PW-1:0] w_q;
    logic [PW-1:0] w_ord;

    // Round to nearest kept step; overflow past full scale saturates.
    function automatic logic [CW-1:0] f_quant(
        input logic [CW-1:0] x,
        input logic [KW-1:0] k
    );
        logic [CW:0] y;
        int          sh;
        f_quant = x;
        y       = '0;
        sh      = 0;
        if (k == '0) begin
            f_quant = '0;
        end else if (int'(k) < CW) begin
            sh = CW - int'(k);
            y  = {1'b0, x} + (ONE << (sh - 1));
            if (y[CW]) begin
                y = {1'b0, {CW{1'b1}}};
            end
            f_quant = y[CW-1:0] & ({CW{1'b1}} << sh);
        end
    endfunction

    assign w_chg_rise = change & ~r_chg_q;
    assign w_kset     = (int'(switch_vals) >= CW) ? K_MAX
                                                  : KW'(switch_vals);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_chg_q <= 1'b1;
            r_kr    <= K_MAX;
            r_kg    <= K_MAX;
            r_kb    <= K_MAX;
        end else begin
            r_chg_q <= change;
            if (w_chg_rise) begin
                unique case (switch_sels)
                    2'd0: r_kr <= w_kset;
                    2'd1: r_kg <= w_kset;
                    2'd2: r_kb <= w_kset;
                    2'd3: begin
                        r_kr <= w_kset;
                        r_kg <= w_kset;
                        r_kb <= w_kset;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_q = '0;
        for (int i = 0; i < NPIX; i++) begin
            w_q[i*PXW+2*CW +: CW] = f_quant(bus.in_pix[i*PXW+2*CW +: CW], r_kr);
            w_q[i*PXW+CW   +: CW] = f_quant(bus.in_pix[i*PXW+CW   +: CW], r_kg);
            w_q[i*PXW      +: CW] = f_quant(bus.in_pix[i*PXW      +: CW], r_kb);
        end
    end

    always_comb begin
        w_ord = r_d1;
        if (swap_gb) begin
            for (int i = 0; i < NPIX; i++) begin
                w_ord[i*PXW+CW +: CW] = r_d1[i*PXW    +: CW];
                w_ord[i*PXW    +: CW] = r_d1[i*PXW+CW +: CW];
            end
        end
    end

    assign w_s2_free = ~r_v2 | bus.out_ready;
    assign w_s1_free = ~r_v1 | w_s2_free;

    // Stages only advance into free slots, so a stalled output holds steady.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_s1_free) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_d1 <= w_q;
                end
            end
            if (w_s2_free) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= w_ord;
                end
            end
            if (r_v2 & bus.out_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_s1_free;
    assign bus.out_valid = r_v2;
    assign bus.out_pix   = r_d2;
    assign beat_cnt      = r_cnt;
endmodule
